// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: free-running h/v counters gated by pix_ce, plus
// registered sync, display-enable, blanked colour and line/frame start pulses.
module vga_sync_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 128,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 9,
   parameter int unsigned V_SYNC   = 3,
   parameter int unsigned V_BP     = 28,
   parameter int unsigned CW       = 10
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          pix_ce,
   input  logic [2:0]    rgb_in,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [2:0]    rgb,
   output logic          line_start,
   output logic          frame_start
);

   localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic [2:0]    rgb_q, rgb_d;
   logic          ls_q, ls_d;
   logic          fs_q, fs_d;

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_ce) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
         end else begin
            h_d = h_q + CW'(1);
         end
      end
   end

   // Decodes use the pre-edge counters so every registered output lags x/y by one step.
   always_comb begin
      de_d    = (h_q < H_VIS) && (v_q < V_VIS);
      hsync_d = !((h_q >= HS_BEG) && (h_q < HS_END));
      vsync_d = !((v_q >= VS_BEG) && (v_q < VS_END));
      rgb_d   = de_d ? rgb_in : '0;
      ls_d    = (h_q == '0);
      fs_d    = (h_q == '0) && (v_q == '0);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         h_q     <= '0;
         v_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         de_q    <= 1'b0;
         rgb_q   <= '0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         if (pix_ce) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
         end else begin
            ls_q <= 1'b0;
            fs_q <= 1'b0;
         end
      end
   end

   assign x           = h_q;
   assign y           = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb         = rgb_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule
